// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests over req/gnt/rvalid,
// and buffers returned instructions with their PCs in an in-order queue for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_signal,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);
    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] alloc_q, alloc_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [31:0]      hold_instr_q, hold_instr_d;
    logic [31:0]      hold_pc_q, hold_pc_d;

    logic [31:0]      slot_pc_q    [DEPTH];
    logic [31:0]      slot_instr_q [DEPTH];

    logic             grant, pop, fill_ev, drop_ev;
    logic [CNT_W-1:0] unfilled;
    logic [CNT_W:0]   occupancy;
    logic [PTR_W-1:0] alloc_idx, fill_idx;

    // Slots are allocated then filled strictly in order from the head, so the
    // queue is fully described by head, allocated count and filled count.
    always_comb begin
        unfilled  = alloc_q - fill_q;
        if_valid  = (fill_q != '0);
        pop       = if_valid && !stall;
        // A slot freed by this cycle's pop may be re-requested immediately,
        // which is what sustains one instruction per cycle.
        occupancy = {1'b0, alloc_q} + {1'b0, discard_q} - {{CNT_W{1'b0}}, pop};
        imem_req  = (state_q != BOOT) && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
        imem_addr = pc_q;
        grant     = imem_req && imem_gnt;
        drop_ev   = imem_rvalid && (discard_q != '0);
        fill_ev   = imem_rvalid && (discard_q == '0) && (unfilled != '0);
        alloc_idx = head_q + alloc_q[PTR_W-1:0];
        fill_idx  = head_q + fill_q[PTR_W-1:0];
        if_instr  = if_valid ? slot_instr_q[head_q] : hold_instr_q;
        if_pc     = if_valid ? slot_pc_q[head_q]    : hold_pc_q;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        head_d       = head_q;
        alloc_d      = alloc_q;
        fill_d       = fill_q;
        discard_d    = discard_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        if (pop) begin
            hold_instr_d = slot_instr_q[head_q];
            hold_pc_d    = slot_pc_q[head_q];
        end

        if (redirect) begin
            pc_d      = redirect_pc & ~32'h3;
            alloc_d   = '0;
            fill_d    = '0;
            // Every in-flight response not consumed this cycle must be dropped later.
            discard_d = discard_q + unfilled - CNT_W'(drop_ev || fill_ev);
            state_d   = (discard_d != '0) ? DRAIN : FETCH;
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            head_d    = head_q + PTR_W'(pop);
            alloc_d   = alloc_q + CNT_W'(grant) - CNT_W'(pop);
            fill_d    = fill_q + CNT_W'(fill_ev) - CNT_W'(pop);
            discard_d = discard_q - CNT_W'(drop_ev);
            case (state_q)
                BOOT:    state_d = FETCH;
                DRAIN:   if (discard_d == '0) state_d = FETCH;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_signal or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            head_q       <= '0;
            alloc_q      <= '0;
            fill_q       <= '0;
            discard_q    <= '0;
            hold_instr_q <= NOP;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            head_q       <= head_d;
            alloc_q      <= alloc_d;
            fill_q       <= fill_d;
            discard_q    <= discard_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // Slot payload needs no reset: only slots inside the filled window are ever read.
    always_ff @(posedge clk_signal) begin
        if (grant) begin
            slot_pc_q[alloc_idx] <= pc_q;
        end
        if (fill_ev) begin
            slot_instr_q[fill_idx] <= imem_rdata;
        end
    end

    // A response with nothing waiting for it is a memory protocol error; a response
    // to a pre-reset request may still land in the boot cycle.
    assert property (@(posedge clk_signal) disable iff (!reset)
        (state_q != BOOT && imem_rvalid) |-> (drop_ev || fill_ev));

endmodule
